// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state type.
package ahbl_pkg;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HW   = 3'b001;
    localparam logic [2:0] SZ_W    = 3'b010;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slave_state_t;

endpackage

// File: rtl/ahbl_lane_ctrl.sv
// Byte-lane decoder: transfer size and low address bits to byte enables,
// flagging unsupported sizes and unaligned halfword/word accesses.
module ahbl_lane_ctrl
    import ahbl_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] be,
    output logic       misalign
);

    // Little-endian lane selection
    always_comb begin
        be       = 4'b0000;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001 << addr_lo;
                misalign = 1'b0;
            end
            SZ_HW: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            SZ_W: begin
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                be       = 4'b0000;
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM responder with configurable wait states and two-cycle ERROR.
// Optional low-region write protection when AHBL_SRAM_WPROT_EN is defined.
module ahbl_sram_slave
    import ahbl_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int WP_WORDS    = 0
) (
    input  logic        HCLK,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

    logic [31:0]   mem_r [DEPTH];

    slave_state_t  state_r;
    logic [3:0]    cnt_r;
    logic [AW-1:0] idx_r;
    logic [3:0]    be_r;
    logic          wr_r;
    logic          hreadyout_r;
    logic          hresp_r;

    logic          accept_s;
    logic          range_err_s;
    logic          wp_err_s;
    logic          illegal_s;
    logic          misalign_s;
    logic [3:0]    be_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   hrdata_s;

    ahbl_lane_ctrl u_lane (
        .size     (HSIZE),
        .addr_lo  (HADDR[1:0]),
        .be       (be_s),
        .misalign (misalign_s)
    );

    assign accept_s    = HSEL && HREADY && ((HTRANS == HT_NONSEQ) || (HTRANS == HT_SEQ));
    assign idx_s       = HADDR[AW+1:2];
    assign range_err_s = ((HADDR >> (AW + 2)) != 32'd0);

`ifdef AHBL_SRAM_WPROT_EN
    assign wp_err_s = HWRITE && (32'(idx_s) < 32'(WP_WORDS));
`else
    assign wp_err_s = 1'b0;
`endif

    assign illegal_s = misalign_s || range_err_s || wp_err_s;

    // Transfer FSM: WAIT and ERR1 hold the bus, DATA and ERR2 may pipeline a new transfer
    always_ff @(posedge HCLK) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            idx_r       <= '0;
            be_r        <= 4'b0000;
            wr_r        <= 1'b0;
            hreadyout_r <= 1'b1;
            hresp_r     <= RESP_OKAY;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r     <= ST_DATA;
                        hreadyout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_r     <= ST_ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= RESP_ERROR;
                end
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept_s) begin
                        idx_r <= idx_s;
                        be_r  <= be_s;
                        wr_r  <= HWRITE;
                        if (illegal_s) begin
                            state_r     <= ST_ERR1;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= RESP_ERROR;
                        end else if (WAIT_STATES != 32'sd0) begin
                            state_r     <= ST_WAIT;
                            cnt_r       <= WS_LOAD;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= RESP_OKAY;
                        end else begin
                            state_r     <= ST_DATA;
                            hreadyout_r <= 1'b1;
                            hresp_r     <= RESP_OKAY;
                        end
                    end else begin
                        state_r     <= ST_IDLE;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= RESP_OKAY;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= RESP_OKAY;
                end
            endcase
        end
    end

    // Write commit at the edge that closes a legal write data phase
    always_ff @(posedge HCLK) begin
        if (!rst && (state_r == ST_DATA) && wr_r) begin
            for (int b = 0; b < 4; b++) begin
                if (be_r[b]) begin
                    mem_r[idx_r][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data is visible only during a read data phase
    always_comb begin
        if ((state_r == ST_DATA) && !wr_r) begin
            hrdata_s = mem_r[idx_r];
        end else begin
            hrdata_s = 32'h0000_0000;
        end
    end

    assign HRDATA    = hrdata_s;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;

endmodule
